// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and the iteration-counter width helper.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // Counter must be able to hold the value WIDTH.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and for
// correcting the sign of products, quotients and remainders.
module muldiv_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] result
);

   assign result = neg ? ((~value) + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up last.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t               state_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic                 is_mul_reg;
   logic                 neg_q_reg;
   logic                 neg_r_reg;
   logic [WIDTH-1:0]     mag_a_reg;
   logic [WIDTH-1:0]     mag_b_reg;
   logic [2*WIDTH-1:0]   acc_reg;
   logic [WIDTH-1:0]     rem_reg;
   logic [WIDTH-1:0]     hi_reg;
   logic [WIDTH-1:0]     lo_reg;
   logic                 done_reg;

   logic                 signed_op;
   logic                 neg_a;
   logic                 neg_b;
   logic [WIDTH-1:0]     abs_a;
   logic [WIDTH-1:0]     abs_b;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       rem_shift;
   logic [WIDTH:0]       rem_diff;
   logic [WIDTH-1:0]     rem_next;
   logic [WIDTH-1:0]     quo_next;
   logic [2*WIDTH-1:0]   prod_fixed;
   logic [WIDTH-1:0]     quo_fixed;
   logic [WIDTH-1:0]     rem_fixed;
   logic [WIDTH-1:0]     fix_hi;
   logic [WIDTH-1:0]     fix_lo;

   assign signed_op = (op == OP_MULT) || (op == OP_DIV);
   assign neg_a     = signed_op & a[WIDTH-1];
   assign neg_b     = signed_op & b[WIDTH-1];

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.neg(neg_a), .value(a), .result(abs_a));
   muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.neg(neg_b), .value(b), .result(abs_b));

   // Multiply: multiplier sits in the low half and shifts out LSB first.
   assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_reg};
   assign mul_next = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                                : {1'b0, acc_reg[2*WIDTH-1:1]};

   // Divide: dividend in the low half shifts out MSB first, quotient shifts in.
   assign rem_shift = {rem_reg, acc_reg[WIDTH-1]};
   assign rem_diff  = rem_shift - {1'b0, mag_b_reg};
   assign rem_next  = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
   assign quo_next  = {acc_reg[WIDTH-2:0], ~rem_diff[WIDTH]};

   muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.neg(neg_q_reg), .value(acc_reg), .result(prod_fixed));
   muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.neg(neg_q_reg), .value(acc_reg[WIDTH-1:0]), .result(quo_fixed));
   muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.neg(neg_r_reg), .value(rem_reg), .result(rem_fixed));

   assign fix_hi = is_mul_reg ? prod_fixed[2*WIDTH-1:WIDTH] : rem_fixed;
   assign fix_lo = is_mul_reg ? prod_fixed[WIDTH-1:0]       : quo_fixed;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         is_mul_reg <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         mag_a_reg  <= '0;
         mag_b_reg  <= '0;
         acc_reg    <= '0;
         rem_reg    <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (flush) begin
            state_reg <= ST_IDLE;
         end else if (hi_we || lo_we) begin
            if (hi_we) hi_reg <= a;
            if (lo_we) lo_reg <= a;
            state_reg <= ST_IDLE;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (start) begin
                     if (op[1] && (b == '0)) begin
                        // Divide by zero: preload the result and pass it through FIX unmodified.
                        is_mul_reg <= 1'b1;
                        neg_q_reg  <= 1'b0;
                        acc_reg    <= {a, {WIDTH{1'b1}}};
                        state_reg  <= ST_FIX;
                     end else begin
                        is_mul_reg <= ~op[1];
                        neg_q_reg  <= neg_a ^ neg_b;
                        neg_r_reg  <= neg_a;
                        mag_a_reg  <= abs_a;
                        mag_b_reg  <= abs_b;
                        acc_reg    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        rem_reg    <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= ST_RUN;
                     end
                  end
               end
               ST_RUN: begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
                  if (is_mul_reg) begin
                     acc_reg <= mul_next;
                  end else begin
                     acc_reg[WIDTH-1:0] <= quo_next;
                     rem_reg            <= rem_next;
                  end
                  if (cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= ST_FIX;
               end
               ST_FIX: begin
                  hi_reg    <= fix_hi;
                  lo_reg    <= fix_lo;
                  done_reg  <= 1'b1;
                  state_reg <= ST_IDLE;
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy = (state_reg != ST_IDLE);
   assign done = done_reg;
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH = 32): results, latency,
// divide-by-zero, abort paths, MTHI/MTLO and reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
      .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   // Launch one op; lat = edge index E_k after which done is seen (-1 on timeout).
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt, output logic done_after);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      bcnt = 0;
      done_after = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            lat = k - 1;
            break;
         end
      end
      @(negedge clk);
      done_after = done;
      $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d busy_cycles=%0d", o, x, y, hi, lo, lat, bcnt);
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks += 4;
      if (hi !== 32'h0)   begin n_fail++; $display("FAIL reset_hi got=%h want=%h", hi, 32'h0); end
      if (lo !== 32'h0)   begin n_fail++; $display("FAIL reset_lo got=%h want=%h", lo, 32'h0); end
      if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
      $display("reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
   endtask

   task automatic test_multu();
      int lat, bc; logic d2;
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, d2);
      n_checks += 5;
      if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got=%h want=%h", hi, 32'hFFFF_FFFE); end
      if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got=%h want=%h", lo, 32'h1); end
      if (lat !== 33)           begin n_fail++; $display("FAIL multu_latency got=%0d want=33", lat); end
      if (bc !== 33)            begin n_fail++; $display("FAIL multu_busy_cycles got=%0d want=33", bc); end
      if (d2 !== 1'b0)          begin n_fail++; $display("FAIL multu_done_pulse got=%b want=0", d2); end
   endtask

   task automatic test_mult();
      int lat, bc; logic d2;
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, lat, bc, d2);
      n_checks += 3;
      if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got=%h want=%h", hi, 32'hFFFF_FFFF); end
      if (lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo got=%h want=%h", lo, 32'hFFFF_FFF1); end
      if (lat !== 33)           begin n_fail++; $display("FAIL mult_latency got=%0d want=33", lat); end
   endtask

   task automatic test_div();
      int lat, bc; logic d2;
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bc, d2);
      n_checks += 2;
      if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg7_2_lo got=%h want=%h", lo, 32'hFFFF_FFFD); end
      if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg7_2_hi got=%h want=%h", hi, 32'hFFFF_FFFF); end
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, d2);
      n_checks += 2;
      if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo got=%h want=%h", lo, 32'h8000_0000); end
      if (hi !== 32'h0)         begin n_fail++; $display("FAIL div_ovf_hi got=%h want=%h", hi, 32'h0); end
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat, bc, d2);
      n_checks += 2;
      if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7_neg2_lo got=%h want=%h", lo, 32'hFFFF_FFFD); end
      if (hi !== 32'h1)         begin n_fail++; $display("FAIL div_7_neg2_hi got=%h want=%h", hi, 32'h1); end
   endtask

   task automatic test_divu_zero();
      int lat, bc; logic d2;
      run_op(2'b11, 32'd7, 32'd0, lat, bc, d2);
      n_checks += 4;
      if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_lo got=%h want=%h", lo, 32'hFFFF_FFFF); end
      if (hi !== 32'd7)         begin n_fail++; $display("FAIL divu0_hi got=%h want=%h", hi, 32'd7); end
      if (lat !== 1)            begin n_fail++; $display("FAIL divu0_latency got=%0d want=1", lat); end
      if (bc !== 1)             begin n_fail++; $display("FAIL divu0_busy_cycles got=%0d want=1", bc); end
   endtask

   task automatic test_flush();
      int seen = 0;
      @(negedge clk);
      op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      n_checks += 1;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b want=0", busy); end
      for (int k = 0; k < 40; k++) begin
         if (done) seen++;
         @(negedge clk);
      end
      n_checks += 3;
      if (seen !== 0)           begin n_fail++; $display("FAIL flush_no_done got=%0d want=0", seen); end
      if (hi !== 32'd7)         begin n_fail++; $display("FAIL flush_hi_kept got=%h want=%h", hi, 32'd7); end
      if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flush_lo_kept got=%h want=%h", lo, 32'hFFFF_FFFF); end
      $display("flush: busy=%b done_seen=%0d hi=%h lo=%h", busy, seen, hi, lo);
   endtask

   task automatic test_start_ignored();
      int lat = -1;
      @(negedge clk);
      op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (done) begin lat = k; break; end
      end
      n_checks += 3;
      if (lat !== 30)     begin n_fail++; $display("FAIL start_busy_latency got=%0d want=30", lat); end
      if (hi !== 32'd0)   begin n_fail++; $display("FAIL start_busy_hi got=%h want=%h", hi, 32'd0); end
      if (lo !== 32'd6)   begin n_fail++; $display("FAIL start_busy_lo got=%h want=%h", lo, 32'd6); end
      $display("start-while-busy: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_mthi();
      @(negedge clk);
      a = 32'h1234; hi_we = 1'b1; op = 2'b01; b = 32'd9; start = 1'b1;
      n_checks += 1;
      if (hi !== 32'd0) begin n_fail++; $display("FAIL mthi_no_bypass got=%h want=%h", hi, 32'd0); end
      @(posedge clk);
      #1 hi_we = 1'b0; start = 1'b0;
      @(negedge clk);
      n_checks += 3;
      if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_hi got=%h want=%h", hi, 32'h1234); end
      if (lo !== 32'd6)    begin n_fail++; $display("FAIL mthi_lo_kept got=%h want=%h", lo, 32'd6); end
      if (busy !== 1'b0)   begin n_fail++; $display("FAIL mthi_start_ignored got=%b want=0", busy); end
      $display("mthi: hi=%h lo=%h busy=%b", hi, lo, busy);
   endtask

   task automatic test_mtlo_abort();
      int seen = 0;
      @(negedge clk);
      op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 a = 32'hABCD; lo_we = 1'b1;
      @(posedge clk);
      #1 lo_we = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 40; k++) begin
         if (done) seen++;
         @(negedge clk);
      end
      n_checks += 4;
      if (busy !== 1'b0)    begin n_fail++; $display("FAIL mtlo_abort_busy got=%b want=0", busy); end
      if (lo !== 32'hABCD)  begin n_fail++; $display("FAIL mtlo_lo got=%h want=%h", lo, 32'hABCD); end
      if (hi !== 32'h1234)  begin n_fail++; $display("FAIL mtlo_hi_kept got=%h want=%h", hi, 32'h1234); end
      if (seen !== 0)       begin n_fail++; $display("FAIL mtlo_no_done got=%0d want=0", seen); end
      $display("mtlo abort: hi=%h lo=%h busy=%b", hi, lo, busy);
   endtask

   task automatic test_rst_mid_run();
      @(negedge clk);
      op = 2'b00; a = 32'd11; b = 32'd13; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks += 4;
      if (hi !== 32'd0)  begin n_fail++; $display("FAIL rst_mid_hi got=%h want=%h", hi, 32'd0); end
      if (lo !== 32'd0)  begin n_fail++; $display("FAIL rst_mid_lo got=%h want=%h", lo, 32'd0); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
      if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got=%b want=0", done); end
      $display("reset mid-run: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
   endtask

   task automatic test_back_to_back();
      int lat, bc; logic d2;
      run_op(2'b11, 32'd100, 32'd7, lat, bc, d2);
      n_checks += 2;
      if (lo !== 32'd14) begin n_fail++; $display("FAIL b2b_divu_lo got=%h want=%h", lo, 32'd14); end
      if (hi !== 32'd2)  begin n_fail++; $display("FAIL b2b_divu_hi got=%h want=%h", hi, 32'd2); end
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, d2);
      n_checks += 2;
      if (lo !== 32'd1)  begin n_fail++; $display("FAIL b2b_mult_lo got=%h want=%h", lo, 32'd1); end
      if (hi !== 32'd0)  begin n_fail++; $display("FAIL b2b_mult_hi got=%h want=%h", hi, 32'd0); end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_divu_zero();
      test_flush();
      test_start_ignored();
      test_mthi();
      test_mtlo_abort();
      test_rst_mid_run();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It executes MULT, MULTU, DIV and DIVU as multi-cycle operations and services MTHI/MTLO writes and MFHI/MFLO reads. It sits in the execute stage beside the ALU. The main decoder drives its op/start/write strobes, and its `busy` output stalls the pipeline. It replaces the single-cycle HI/LO write path, and its operand width is parametrised.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `flush` input 1: abort any in-flight operation; HI/LO unchanged.
- `start` input 1: request an operation; sampled only in IDLE.
- `op` input 2: operation select. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `a` input WIDTH: rs operand (multiplicand / dividend).
- `b` input WIDTH: rt operand (multiplier / divisor).
- `hi_we` input 1: MTHI strobe, writes `a` into HI.
- `lo_we` input 1: MTLO strobe, writes `a` into LO.
- `busy` output 1: operation in flight; the pipeline stalls on it.
- `done` output 1: one-cycle pulse; HI/LO hold the new result in this cycle.
- `hi` output WIDTH: registered HI (MFHI source).
- `lo` output WIDTH: registered LO (MFLO source).

## Operation
- **States:** IDLE, RUN, FIX. `busy` = (state != IDLE).
- **IDLE + start, normal operand:**
  - Latch the magnitudes of `a` and `b`. Signed ops take the absolute value; unsigned ops pass operands through.
  - Latch the result signs.
  - Clear the iteration counter and go to RUN.
- **IDLE + start, DIV/DIVU with b == 0:** go straight to FIX. The result is LO = all ones, HI = a.
- **RUN:**
  - Performs one iteration per cycle, exactly `WIDTH` iterations, then goes to FIX.
  - Multiply: shift-add on a 2×WIDTH accumulator.
  - Divide: restoring divide, with a WIDTH+1-bit partial remainder and one quotient bit per cycle.
- **FIX:**
  - Apply the two's-complement sign correction.
  - Signed multiply: the 2×WIDTH product is negated if the operand signs differ.
  - Signed divide: the quotient is negated if the signs differ; the remainder takes the sign of `a`.
  - Write HI = product[2W-1:W] / remainder and LO = product[W-1:0] / quotient.
  - Set `done` for one cycle and return to IDLE.
- **Signed overflow:** INT_MIN / −1 gives LO = INT_MIN, HI = 0. There is no trap.
- **Priority:** `rst` > `flush` > `hi_we`/`lo_we` > `start`.
  - `flush` in any state: go to IDLE next cycle and discard the result. `done` stays low.
  - `hi_we`/`lo_we` in IDLE: write HI/LO. A `start` in the same cycle is ignored.
  - `hi_we`/`lo_we` while busy: write HI/LO and abort the in-flight op, as for `flush`.
  - `start` while busy is ignored.

## Timing
- **Reset values:** `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state = IDLE.
  - Reset mid-operation returns to these values on the next edge.
- **Normal operation, with start accepted at edge E0:**
  - RUN covers edges E1..E`WIDTH`.
  - FIX writes HI/LO at edge E(`WIDTH`+1).
  - `done` and the new `hi`/`lo` are visible in the cycle after E(`WIDTH`+1).
  - `busy` is high for `WIDTH`+1 cycles, falling together with the rise of `done`.
- **Divide by zero:** FIX at E1, `done` in the following cycle, `busy` high for 1 cycle.
- **MTHI/MTLO:** take effect on the next edge, no bypass.
- **`done` never stays high** for two consecutive cycles.

## Structure
- **Shared package `muldiv_pkg`:**
  - op encodings `OP_MULT`/`OP_MULTU`/`OP_DIV`/`OP_DIVU`;
  - state encoding IDLE/RUN/FIX;
  - counter width, clog2(`WIDTH`+1).
- **Sub-module `muldiv_sign_fix`** (combinational): conditional two's-complement negate, parametrised in width. It is instantiated for operand magnitudes and for result correction.
- The datapath and FSM stay in `muldiv_unit`.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. `done` in the cycle after E33, `busy` high for 33 cycles.
- **MULT:** −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- **DIV:**
  - −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **DIVU by zero:** 7 / 0 → LO = 0xFFFFFFFF, HI = 7. `done` in the cycle after E1.
- **Abort:**
  - `flush` asserted on the 10th RUN cycle → `busy` low next cycle, no `done`, HI/LO keep their prior values.
  - `start` pulsed while busy is ignored.
- **HI/LO writes and reset:**
  - MTHI 0x1234 while idle → `hi` = 0x1234 next cycle.
  - MTLO during RUN aborts the op.
  - `rst` mid-RUN → all outputs 0 next cycle.
